// File: rtl/line_transfer_controller_if.sv
//==============================================================================
// Module : line_transfer_controller_if
// Brief  : Request, datalines and memory-bus signals of the line transfer controller.
// Rev    : 1.0
//==============================================================================
`default_nettype none

typedef enum logic [1:0] {
    BYTE      = 2'd0,
    HALF_WORD = 2'd1,
    WORD      = 2'd2
} memory_operation_size_e;

interface line_transfer_controller_if #(
    parameter int XLEN             = 32,
    parameter int SET_SIZE         = 2,
    parameter int WORD_SELECT_SIZE = 3,
    parameter int BYTE_SELECT_SIZE = 2,
    parameter int TAG_SIZE         = XLEN - SET_SIZE - WORD_SELECT_SIZE - BYTE_SELECT_SIZE
);
    logic                        req_valid;
    logic                        req_ready;
    logic                        req_writeback;
    logic                        req_fill;
    logic [SET_SIZE-1:0]         req_set;
    logic [TAG_SIZE-1:0]         req_old_tag;
    logic [TAG_SIZE-1:0]         req_new_tag;
    logic                        done;

    logic                        dl_owner;
    logic                        dl_perform_write;
    logic [SET_SIZE-1:0]         dl_set;
    memory_operation_size_e      dl_op_size;
    logic [WORD_SELECT_SIZE-1:0] dl_word_select;
    logic [BYTE_SELECT_SIZE-1:0] dl_byte_select;
    logic [XLEN-1:0]             dl_word_to_store;
    logic [XLEN-1:0]             dl_fetched_word;

    logic                        mem_req_valid;
    logic                        mem_req_ready;
    logic                        mem_req_we;
    logic [XLEN-1:0]             mem_req_addr;
    logic [XLEN-1:0]             mem_req_wdata;
    logic                        mem_rsp_valid;
    logic [XLEN-1:0]             mem_rsp_rdata;

    // Controller side
    modport slave (
        input  req_valid, req_writeback, req_fill, req_set, req_old_tag, req_new_tag,
        output req_ready, done,
        output dl_owner, dl_perform_write, dl_set, dl_op_size, dl_word_select,
        output dl_byte_select, dl_word_to_store,
        input  dl_fetched_word,
        output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata
    );

    // Requester / datalines / memory side
    modport master (
        output req_valid, req_writeback, req_fill, req_set, req_old_tag, req_new_tag,
        input  req_ready, done,
        input  dl_owner, dl_perform_write, dl_set, dl_op_size, dl_word_select,
        input  dl_byte_select, dl_word_to_store,
        output dl_fetched_word,
        input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
        output mem_req_ready, mem_rsp_valid, mem_rsp_rdata
    );
endinterface

`default_nettype wire

// File: rtl/line_transfer_controller.sv
//==============================================================================
// Module : line_transfer_controller
// Brief  : Sequences whole-line writeback and fill between datalines and memory.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module line_transfer_controller #(
    parameter int XLEN             = 32,
    parameter int NUM_SETS         = 4,
    parameter int SET_SIZE         = 2,
    parameter int WORDS_PER_LINE   = 8,
    parameter int WORD_SELECT_SIZE = 3,
    parameter int BYTE_SELECT_SIZE = 2,
    parameter int TAG_SIZE         = XLEN - SET_SIZE - WORD_SELECT_SIZE - BYTE_SELECT_SIZE
) (
    input  logic                         clk,
    input  logic                         reset,
    line_transfer_controller_if.slave    bus
);

    localparam logic [WORD_SELECT_SIZE-1:0] c_LAST_WORD = WORD_SELECT_SIZE'(WORDS_PER_LINE - 1);
    localparam logic [SET_SIZE-1:0]         c_SET_MASK  = SET_SIZE'(NUM_SETS - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WB_REQ    = 3'd1,
        FILL_REQ  = 3'd2,
        FILL_WAIT = 3'd3,
        DONE      = 3'd4
    } state_e;

    state_e                      r_state;
    state_e                      w_state_next;
    logic [WORD_SELECT_SIZE-1:0] r_word;
    logic [WORD_SELECT_SIZE-1:0] w_word_next;
    logic [WORD_SELECT_SIZE-1:0] w_word_inc;
    logic [SET_SIZE-1:0]         r_set;
    logic [TAG_SIZE-1:0]         r_old_tag;
    logic [TAG_SIZE-1:0]         r_new_tag;
    logic                        r_fill;
    logic [TAG_SIZE-1:0]         w_tag;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_word  <= '0;
        end else begin
            r_state <= w_state_next;
            r_word  <= w_word_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_set     <= '0;
            r_old_tag <= '0;
            r_new_tag <= '0;
            r_fill    <= 1'b0;
        end else if (r_state == IDLE && bus.req_valid) begin
            r_set     <= bus.req_set & c_SET_MASK;
            r_old_tag <= bus.req_old_tag;
            r_new_tag <= bus.req_new_tag;
            r_fill    <= bus.req_fill;
        end
    end

    // Counter wraps to zero when leaving the last word so the next phase starts clean
    assign w_word_inc = (r_word == c_LAST_WORD) ? '0 : r_word + WORD_SELECT_SIZE'(1);

    always_comb begin
        w_state_next = r_state;
        w_word_next  = r_word;
        case (r_state)
            IDLE: begin
                if (bus.req_valid) begin
                    w_word_next = '0;
                    if (bus.req_writeback)
                        w_state_next = WB_REQ;
                    else if (bus.req_fill)
                        w_state_next = FILL_REQ;
                    else
                        w_state_next = DONE;
                end
            end
            WB_REQ: begin
                if (bus.mem_req_ready) begin
                    w_word_next = w_word_inc;
                    if (r_word == c_LAST_WORD)
                        w_state_next = r_fill ? FILL_REQ : DONE;
                end
            end
            FILL_REQ: begin
                if (bus.mem_req_ready)
                    w_state_next = FILL_WAIT;
            end
            FILL_WAIT: begin
                if (bus.mem_rsp_valid) begin
                    w_word_next  = w_word_inc;
                    w_state_next = (r_word == c_LAST_WORD) ? DONE : FILL_REQ;
                end
            end
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    assign w_tag = (r_state == WB_REQ) ? r_old_tag : r_new_tag;

    always_comb begin
        bus.req_ready        = (r_state == IDLE);
        bus.done             = (r_state == DONE);
        bus.dl_owner         = (r_state == WB_REQ) || (r_state == FILL_REQ) || (r_state == FILL_WAIT);
        bus.dl_perform_write = 1'b0;
        bus.dl_set           = r_set;
        bus.dl_op_size       = WORD;
        bus.dl_word_select   = r_word;
        bus.dl_byte_select   = '0;
        bus.dl_word_to_store = '0;
        bus.mem_req_valid    = (r_state == WB_REQ) || (r_state == FILL_REQ);
        bus.mem_req_we       = (r_state == WB_REQ);
        bus.mem_req_addr     = {w_tag, r_set, r_word, {BYTE_SELECT_SIZE{1'b0}}};
        bus.mem_req_wdata    = '0;
        if (r_state == WB_REQ)
            bus.mem_req_wdata = bus.dl_fetched_word;
        if (r_state == FILL_WAIT) begin
            bus.dl_perform_write = bus.mem_rsp_valid;
            bus.dl_word_to_store = bus.mem_rsp_rdata;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_line_transfer_controller.sv
//==============================================================================
// Module : tb_line_transfer_controller
// Brief  : Scoreboard bench with a memory responder and datalines model.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module tb_line_transfer_controller;

    localparam int XLEN = 32;
    localparam int TAG  = 25;
    localparam int W    = 8;
    localparam logic [31:0] RSP_KEY = 32'hA5A5A5A5;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    line_transfer_controller_if #(.XLEN(32), .SET_SIZE(2), .WORD_SELECT_SIZE(3), .BYTE_SELECT_SIZE(2)) bus ();

    line_transfer_controller #(
        .XLEN(32), .NUM_SETS(4), .SET_SIZE(2), .WORDS_PER_LINE(8),
        .WORD_SELECT_SIZE(3), .BYTE_SELECT_SIZE(2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; } beat_t;
    typedef struct { logic [1:0] set; logic [2:0] word; logic [31:0] data; } dlw_t;

    beat_t       exp_beats[$];
    dlw_t        exp_dlw[$];
    int          exp_done = 0;
    logic [31:0] ref_dl [4][8];
    logic [31:0] dl_mem [4][8];
    int          n_checks = 0;
    int          n_errors = 0;

    bit zero_wait   = 1'b1;
    bit spurious_on = 1'b0;
    bit hold_word3  = 1'b0;
    int stall_word4 = 0;

    assign bus.dl_fetched_word = dl_mem[bus.dl_set][bus.dl_word_select];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory responder: one outstanding read, answered after a lag with addr^KEY
    initial begin : responder
        bit          pend = 1'b0;
        logic [31:0] pend_addr = '0;
        int          pend_lag = 0;
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_rdata = '0;
        forever begin
            @(negedge clk);
            bus.mem_rsp_valid = 1'b0;
            bus.mem_rsp_rdata = '0;
            if (reset) begin
                pend = 1'b0;
                bus.mem_req_ready = 1'b0;
            end else begin
                if (pend) begin
                    if (pend_lag > 0)
                        pend_lag--;
                    else if (!(hold_word3 && pend_addr[4:2] == 3'd3)) begin
                        bus.mem_rsp_valid = 1'b1;
                        bus.mem_rsp_rdata = pend_addr ^ RSP_KEY;
                        pend = 1'b0;
                    end
                end else if (spurious_on && $urandom_range(0, 2) == 0) begin
                    bus.mem_rsp_valid = 1'b1;
                    bus.mem_rsp_rdata = $urandom;
                end
                if (stall_word4 > 0 && bus.mem_req_valid && bus.mem_req_we && bus.mem_req_addr[4:2] == 3'd4) begin
                    bus.mem_req_ready = 1'b0;
                    stall_word4--;
                    bus.mem_rsp_valid = 1'b1;
                    bus.mem_rsp_rdata = 32'hDEADBEEF;
                end else begin
                    bus.mem_req_ready = zero_wait ? 1'b1 : ($urandom_range(0, 3) != 0);
                end
                #1;
                if (bus.mem_req_valid && bus.mem_req_ready && !bus.mem_req_we) begin
                    pend      = 1'b1;
                    pend_addr = bus.mem_req_addr;
                    pend_lag  = zero_wait ? 0 : int'($urandom_range(0, 3));
                end
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents a beat, write or done
    initial begin : monitor
        bit          hold_pend = 1'b0;
        logic        hold_we = 1'b0;
        logic [31:0] hold_addr = '0;
        logic [31:0] hold_wdata = '0;
        logic [2:0]  hold_word = '0;
        beat_t       b;
        dlw_t        d;
        forever begin
            @(negedge clk);
            #2;
            if (reset) begin
                hold_pend = 1'b0;
            end else begin
                if (hold_pend) begin
                    chk("req_held_valid", 64'(bus.mem_req_valid), 64'd1);
                    chk("req_held_addr", 64'(bus.mem_req_addr), 64'(hold_addr));
                    chk("req_held_word", 64'(bus.dl_word_select), 64'(hold_word));
                    if (hold_we)
                        chk("req_held_wdata", 64'(bus.mem_req_wdata), 64'(hold_wdata));
                end
                hold_pend = 1'b0;
                if (bus.mem_req_valid) begin
                    if (bus.mem_req_ready) begin
                        chk("beat_expected", 64'(exp_beats.size() != 0), 64'd1);
                        if (exp_beats.size() != 0) begin
                            b = exp_beats.pop_front();
                            chk("beat_we", 64'(bus.mem_req_we), 64'(b.we));
                            chk("beat_addr", 64'(bus.mem_req_addr), 64'(b.addr));
                            if (b.we)
                                chk("beat_wdata", 64'(bus.mem_req_wdata), 64'(b.wdata));
                        end
                    end else begin
                        hold_pend  = 1'b1;
                        hold_we    = bus.mem_req_we;
                        hold_addr  = bus.mem_req_addr;
                        hold_wdata = bus.mem_req_wdata;
                        hold_word  = bus.dl_word_select;
                    end
                end
                if (bus.dl_perform_write) begin
                    chk("dl_write_expected", 64'(exp_dlw.size() != 0), 64'd1);
                    if (exp_dlw.size() != 0) begin
                        d = exp_dlw.pop_front();
                        chk("dl_write_set", 64'(bus.dl_set), 64'(d.set));
                        chk("dl_write_word", 64'(bus.dl_word_select), 64'(d.word));
                        chk("dl_write_data", 64'(bus.dl_word_to_store), 64'(d.data));
                    end
                    dl_mem[bus.dl_set][bus.dl_word_select] = bus.dl_word_to_store;
                end
                if (bus.done) begin
                    chk("done_expected", 64'(exp_done > 0), 64'd1);
                    if (exp_done > 0) exp_done--;
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, 64'(bus.req_ready), 64'd1);
        chk({tag, "_done"}, 64'(bus.done), 64'd0);
        chk({tag, "_dl_owner"}, 64'(bus.dl_owner), 64'd0);
        chk({tag, "_dl_write"}, 64'(bus.dl_perform_write), 64'd0);
        chk({tag, "_dl_set"}, 64'(bus.dl_set), 64'd0);
        chk({tag, "_op_size"}, 64'(bus.dl_op_size), 64'(WORD));
        chk({tag, "_word"}, 64'(bus.dl_word_select), 64'd0);
        chk({tag, "_byte"}, 64'(bus.dl_byte_select), 64'd0);
        chk({tag, "_store"}, 64'(bus.dl_word_to_store), 64'd0);
        chk({tag, "_mem_valid"}, 64'(bus.mem_req_valid), 64'd0);
        chk({tag, "_mem_we"}, 64'(bus.mem_req_we), 64'd0);
        chk({tag, "_mem_addr"}, 64'(bus.mem_req_addr), 64'd0);
        chk({tag, "_mem_wdata"}, 64'(bus.mem_req_wdata), 64'd0);
    endtask

    // Reference model: a writeback streams the current line out, a fill replaces it
    task automatic start_req(input bit wb, input bit fill, input logic [1:0] set,
                             input logic [TAG-1:0] ot, input logic [TAG-1:0] nt);
        logic [31:0] a;
        if (wb)
            for (int w = 0; w < W; w++)
                exp_beats.push_back('{we: 1'b1, addr: {ot, set, 3'(w), 2'b00}, wdata: ref_dl[set][w]});
        if (fill)
            for (int w = 0; w < W; w++) begin
                a = {nt, set, 3'(w), 2'b00};
                exp_beats.push_back('{we: 1'b0, addr: a, wdata: 32'd0});
                exp_dlw.push_back('{set: set, word: 3'(w), data: a ^ RSP_KEY});
                ref_dl[set][w] = a ^ RSP_KEY;
            end
        exp_done++;
        @(negedge clk);
        chk("ready_before_req", 64'(bus.req_ready), 64'd1);
        bus.req_valid     = 1'b1;
        bus.req_writeback = wb;
        bus.req_fill      = fill;
        bus.req_set       = set;
        bus.req_old_tag   = ot;
        bus.req_new_tag   = nt;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        bit seen = 1'b0;
        lat = 0;
        while (!seen && lat < 1000) begin
            @(negedge clk);
            lat++;
            #3;
            if (bus.done) seen = 1'b1;
        end
        chk("done_seen", 64'(seen), 64'd1);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
        $fatal(1, "timeout");
    end

    initial begin : main
        int          lat;
        bit          reached;
        logic [31:0] saved [8];
        bus.req_valid     = 1'b0;
        bus.req_writeback = 1'b0;
        bus.req_fill      = 1'b0;
        bus.req_set       = '0;
        bus.req_old_tag   = '0;
        bus.req_new_tag   = '0;
        for (int s = 0; s < 4; s++)
            for (int w = 0; w < W; w++) begin
                ref_dl[s][w] = (s == 1) ? 32'(w) * 32'h11111111 : 32'h00C0_0000 + 32'(s * 16 + w);
                dl_mem[s][w] = ref_dl[s][w];
            end

        repeat (3) @(negedge clk);
        #2 check_reset_outputs("reset");
        @(posedge clk);
        #2 reset = 1'b0;

        // Fill only, set 2
        start_req(1'b0, 1'b1, 2'd2, 25'h0, 25'h1234);
        wait_done(lat);
        chk("fill_latency", 64'(lat), 64'd17);

        // Writeback only, set 1 (known pattern)
        start_req(1'b1, 1'b0, 2'd1, 25'h0ABCD, 25'h0);
        wait_done(lat);
        chk("wb_latency", 64'(lat), 64'd9);

        // Writeback then fill, set 3
        start_req(1'b1, 1'b1, 2'd3, 25'h1555, 25'h0777);
        wait_done(lat);
        chk("wb_fill_latency", 64'(lat), 64'd25);

        // Neither flag
        start_req(1'b0, 1'b0, 2'd0, 25'h1, 25'h2);
        wait_done(lat);
        chk("noop_latency", 64'(lat), 64'd1);

        // Writeback with 5-cycle stall on word 4 and a spurious response
        stall_word4 = 5;
        start_req(1'b1, 1'b0, 2'd2, 25'h0BEEF, 25'h0);
        wait_done(lat);
        chk("stall_latency", 64'(lat), 64'd14);

        // Async reset while waiting on word 3 of a fill
        for (int w = 0; w < W; w++) saved[w] = ref_dl[0][w];
        hold_word3 = 1'b1;
        start_req(1'b0, 1'b1, 2'd0, 25'h0, 25'h0F0F);
        reached = 1'b0;
        for (int i = 0; i < 200 && !reached; i++) begin
            @(negedge clk);
            #3;
            if (bus.dl_owner && !bus.mem_req_valid && bus.dl_word_select == 3'd3) reached = 1'b1;
        end
        chk("abort_reached_word3", 64'(reached), 64'd1);
        @(posedge clk);
        #2 reset = 1'b1;
        #1 check_reset_outputs("abort");
        exp_beats.delete();
        exp_dlw.delete();
        exp_done = 0;
        for (int w = 3; w < W; w++) ref_dl[0][w] = saved[w];
        hold_word3 = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        start_req(1'b0, 1'b1, 2'd0, 25'h0, 25'h0333);
        wait_done(lat);
        chk("post_abort_latency", 64'(lat), 64'd17);

        // Randomized requests with random ready, response lag and spurious responses
        zero_wait   = 1'b0;
        spurious_on = 1'b1;
        for (int i = 0; i < 20; i++) begin
            start_req(1'($urandom), 1'($urandom), 2'($urandom), 25'($urandom), 25'($urandom));
            wait_done(lat);
        end

        repeat (3) @(negedge clk);
        chk("beats_drained", 64'(exp_beats.size()), 64'd0);
        chk("dl_writes_drained", 64'(exp_dlw.size()), 64'd0);
        chk("done_drained", 64'(exp_done), 64'd0);
        for (int s = 0; s < 4; s++)
            for (int w = 0; w < W; w++)
                chk($sformatf("dl_final_%0d_%0d", s, w), 64'(dl_mem[s][w]), 64'(ref_dl[s][w]));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
